// File: rtl/barrier_arrival_gate.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : barrier_arrival_gate
// Brief   : Per-level count of unreleased barrier arrivals; gates issue.
// Rev     : 1.0  initial release
// ----------------------------------------------------------------------------
module barrier_arrival_gate #(
  parameter int NUM_LEVELS = 4,
  parameter int MAX_AHEAD  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_LEVELS-1:0] in_valid,
  input  logic [NUM_LEVELS-1:0] in_barrier,
  output logic [NUM_LEVELS-1:0] out_ready,
  output logic [NUM_LEVELS-1:0] out_wait,
  input  logic                  in_release,
  output logic                  out_outstanding_any,
  output logic                  out_error
);

  localparam logic [3:0] C_MAX_AHEAD = 4'(MAX_AHEAD);
  localparam logic [3:0] C_CNT_MAX   = 4'd15;

  logic [NUM_LEVELS-1:0][3:0] cnt_q;
  logic [NUM_LEVELS-1:0][3:0] cnt_d;
  logic [NUM_LEVELS-1:0]      ready_q;
  logic [NUM_LEVELS-1:0]      ready_d;
  logic [NUM_LEVELS-1:0]      wait_q;
  logic [NUM_LEVELS-1:0]      accept;
  logic [NUM_LEVELS-1:0]      dec;
  logic [NUM_LEVELS-1:0]      zero_lvl;
  logic [NUM_LEVELS-1:0]      ovf;
  logic                       any_q;
  logic                       any_d;
  logic                       error_q;
  logic                       error_d;

  // ready_q is derived from the counters one edge earlier, so no input reaches out_ready.
  assign accept = in_valid & in_barrier & ready_q;

  always_comb begin
    cnt_d    = cnt_q;
    ready_d  = '0;
    dec      = '0;
    zero_lvl = '0;
    ovf      = '0;
    any_d    = 1'b0;
    error_d  = error_q;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      zero_lvl[i] = (cnt_q[i] == 4'd0);
      dec[i]      = in_release && !zero_lvl[i];
      ovf[i]      = accept[i] && (cnt_q[i] == C_CNT_MAX);
      if (accept[i] && !dec[i] && !ovf[i]) begin
        cnt_d[i] = cnt_q[i] + 4'd1;
      end else if (dec[i] && !accept[i]) begin
        cnt_d[i] = cnt_q[i] - 4'd1;
      end
      ready_d[i] = (cnt_d[i] < C_MAX_AHEAD);
      any_d      = any_d | (cnt_d[i] != 4'd0);
    end
    error_d = error_q | (in_release & (|zero_lvl)) | (|ovf);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      ready_q <= '0;
      wait_q  <= '0;
      any_q   <= 1'b0;
      error_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      wait_q  <= accept;
      any_q   <= any_d;
      error_q <= error_d;
    end
  end

  assign out_ready           = ready_q;
  assign out_wait            = wait_q;
  assign out_outstanding_any = any_q;
  assign out_error           = error_q;

endmodule
`default_nettype wire

// File: tb/tb_barrier_arrival_gate.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : tb_barrier_arrival_gate
// Brief   : Directed bench; dut_a has MAX_AHEAD=1, dut_b has MAX_AHEAD=2.
// Rev     : 1.0  initial release
// ----------------------------------------------------------------------------
module tb_barrier_arrival_gate;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] va, ba, vb, bb;
  logic       rel_a, rel_b;
  logic [1:0] rdy_a, wait_a, rdy_b, wait_b;
  logic       any_a, err_a, any_b, err_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  barrier_arrival_gate #(.NUM_LEVELS(2), .MAX_AHEAD(1)) dut_a (
    .clk(clk), .reset(reset), .in_valid(va), .in_barrier(ba),
    .out_ready(rdy_a), .out_wait(wait_a), .in_release(rel_a),
    .out_outstanding_any(any_a), .out_error(err_a)
  );

  barrier_arrival_gate #(.NUM_LEVELS(2), .MAX_AHEAD(2)) dut_b (
    .clk(clk), .reset(reset), .in_valid(vb), .in_barrier(bb),
    .out_ready(rdy_b), .out_wait(wait_b), .in_release(rel_b),
    .out_outstanding_any(any_b), .out_error(err_b)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    va = 2'b00; ba = 2'b00; vb = 2'b00; bb = 2'b00;
    rel_a = 1'b0; rel_b = 1'b0;
    #3;
    check("rst_ready_a", 8'(rdy_a), 8'h0);
    check("rst_wait_a",  8'(wait_a), 8'h0);
    check("rst_any_a",   8'(any_a), 8'h0);
    check("rst_err_a",   8'(err_a), 8'h0);

    // Barriers presented during reset must not be accepted
    va = 2'b11; ba = 2'b11;
    tick(); tick();
    check("rst_hold_ready", 8'(rdy_a), 8'h0);
    check("rst_hold_wait",  8'(wait_a), 8'h0);
    va = 2'b00; ba = 2'b00;
    #2 reset = 1'b1;
    #1 check("predge_ready", 8'(rdy_a), 8'h0);
    tick();
    check("post_rst_ready_a", 8'(rdy_a), 8'h3);
    check("post_rst_ready_b", 8'(rdy_b), 8'h3);
    check("post_rst_wait_a",  8'(wait_a), 8'h0);

    // Basic arrive/release flow, MAX_AHEAD=1
    va = 2'b01; ba = 2'b01;
    tick();
    check("basic_wait_c1",  8'(wait_a), 8'h1);
    check("basic_ready_c1", 8'(rdy_a), 8'h2);
    check("basic_any_c1",   8'(any_a), 8'h1);
    va = 2'b00; ba = 2'b00;
    tick();
    check("basic_wait_c2",  8'(wait_a), 8'h0);
    check("basic_ready_c2", 8'(rdy_a), 8'h2);
    tick();
    va = 2'b10; ba = 2'b10;
    tick();
    check("basic_wait_c4",  8'(wait_a), 8'h2);
    check("basic_ready_c4", 8'(rdy_a), 8'h0);
    va = 2'b00; ba = 2'b00;
    tick();
    rel_a = 1'b1;
    tick();
    rel_a = 1'b0;
    check("basic_ready_c6", 8'(rdy_a), 8'h3);
    check("basic_any_c6",   8'(any_a), 8'h0);
    check("basic_err_c6",   8'(err_a), 8'h0);
    check("basic_wait_c6",  8'(wait_a), 8'h0);

    // Non-barrier pass-through for 10 cycles
    va = 2'b01; ba = 2'b00;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("pass_ready", 8'(rdy_a), 8'h3);
      check("pass_wait",  8'(wait_a), 8'h0);
      check("pass_any",   8'(any_a), 8'h0);
    end
    // in_barrier without in_valid is ignored
    va = 2'b00; ba = 2'b11;
    tick();
    check("novalid_wait",  8'(wait_a), 8'h0);
    check("novalid_ready", 8'(rdy_a), 8'h3);
    ba = 2'b00;

    // Running ahead, MAX_AHEAD=2
    vb = 2'b11; bb = 2'b11;
    tick();
    check("ahead_wait1",  8'(wait_b), 8'h3);
    check("ahead_ready1", 8'(rdy_b), 8'h3);
    vb = 2'b01; bb = 2'b01;
    tick();
    check("ahead_wait2",  8'(wait_b), 8'h1);
    check("ahead_ready2", 8'(rdy_b), 8'h2);
    check("ahead_cnt0_2", 8'(dut_b.cnt_q[0]), 8'h2);
    vb = 2'b00; bb = 2'b00;
    rel_b = 1'b1;
    tick();
    rel_b = 1'b0;
    check("ahead_rel_ready", 8'(rdy_b), 8'h3);
    check("ahead_rel_cnt0",  8'(dut_b.cnt_q[0]), 8'h1);
    check("ahead_rel_any",   8'(any_b), 8'h1);
    check("ahead_rel_err",   8'(err_b), 8'h0);

    // Simultaneous accept and release on level 0 (level 1 kept non-zero)
    vb = 2'b10; bb = 2'b10;
    tick();
    check("sim_pre_wait", 8'(wait_b), 8'h2);
    vb = 2'b01; bb = 2'b01; rel_b = 1'b1;
    tick();
    vb = 2'b00; bb = 2'b00; rel_b = 1'b0;
    check("sim_cnt0",  8'(dut_b.cnt_q[0]), 8'h1);
    check("sim_wait",  8'(wait_b), 8'h1);
    check("sim_ready", 8'(rdy_b), 8'h3);
    check("sim_err",   8'(err_b), 8'h0);
    vb = 2'b10; bb = 2'b10;
    tick();
    vb = 2'b00; bb = 2'b00; rel_b = 1'b1;
    tick();
    rel_b = 1'b0;
    check("drain_any", 8'(any_b), 8'h0);
    check("drain_err", 8'(err_b), 8'h0);

    // Release underflow
    rel_b = 1'b1;
    tick();
    rel_b = 1'b0;
    check("uf_err",   8'(err_b), 8'h1);
    check("uf_cnt0",  8'(dut_b.cnt_q[0]), 8'h0);
    check("uf_any",   8'(any_b), 8'h0);
    check("uf_ready", 8'(rdy_b), 8'h3);
    tick(); tick();
    check("uf_sticky", 8'(err_b), 8'h1);

    // Asynchronous reset mid-operation with an out_wait pulse live
    va = 2'b01; ba = 2'b01;
    tick();
    va = 2'b10; ba = 2'b10;
    tick();
    va = 2'b00; ba = 2'b00;
    check("ar_pre_wait", 8'(wait_a), 8'h2);
    check("ar_pre_any",  8'(any_a), 8'h1);
    #2 reset = 1'b0;
    #1;
    check("ar_ready", 8'(rdy_a), 8'h0);
    check("ar_wait",  8'(wait_a), 8'h0);
    check("ar_any",   8'(any_a), 8'h0);
    check("ar_err_b", 8'(err_b), 8'h0);
    tick();
    #2 reset = 1'b1;
    tick();
    check("ar_post_ready", 8'(rdy_a), 8'h3);
    check("ar_post_wait",  8'(wait_a), 8'h0);
    check("ar_post_any",   8'(any_a), 8'h0);
    tick();
    check("ar_post_wait2", 8'(wait_a), 8'h0);
    check("ar_post_err_b", 8'(err_b), 8'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
